logs_orbit_capture: RTL
=======================

LOGS_ORBIT_CAPTURE -- requirements
Module: logs_orbit_capture

Interface
REQ-001 The block SHALL have parameter FRAC, default 4: fraction bits of x (0.FRAC fixed-point).
REQ-002 The block SHALL have parameter DEPTH, default 8 (power of two, >=2): number of orbit samples stored.
REQ-003 The block SHALL have parameter SETTLE, default 16 (>=0): number of transient iterates discarded before capture.
REQ-004 The block SHALL have port clk, input, 1 bit: the only clock, all state on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle pulse that begins a new capture (e.g. after r changes).
REQ-007 The block SHALL have port x, input, FRAC bits: current iterate from the map iterator.
REQ-008 The block SHALL have port next_ready, input, 1 bit: one-cycle pulse marking x as a new valid iterate.
REQ-009 The block SHALL have port rd_addr, input, clog2(DEPTH) bits: buffer read index.
REQ-010 The block SHALL have port rd_data, output, FRAC bits: registered buffer[rd_addr].
REQ-011 The block SHALL have port q_value, input, FRAC bits: value to test for orbit membership (plot row).
REQ-012 The block SHALL have port q_hit, output, 1 bit: registered; 1 when q_value equals any stored sample and done=1.
REQ-013 The block SHALL have ports busy and done, outputs, 1 bit each: busy=1 in SETTLE/CAPTURE; done=1 in DONE.

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE, CAPTURE, DONE; busy/done are decoded from state.
REQ-015 start in any state SHALL go to SETTLE (or CAPTURE if SETTLE=0) next cycle, clearing the settle count, write index and period.
REQ-016 In SETTLE, each next_ready pulse SHALL increment the settle counter; the SETTLE-th pulse moves to CAPTURE without storing x.
REQ-017 In CAPTURE, each next_ready pulse SHALL write x to buffer[wr_idx] and increment wr_idx; the write at wr_idx=DEPTH-1 moves to DONE.
REQ-018 wr_idx SHALL NOT wrap: no buffer writes occur in DONE or IDLE; the buffer holds its contents until the next CAPTURE overwrites it.
REQ-019 start and next_ready in the same cycle SHALL apply start only; that iterate is neither counted nor stored.
REQ-020 next_ready in IDLE or DONE SHALL be ignored.
REQ-021 rd_data SHALL equal buffer[rd_addr] as sampled at the previous clock edge (1-cycle latency), in every state.
REQ-022 q_hit SHALL be computed from the previous cycle's q_value and buffer, with 1-cycle latency, and SHALL be 0 unless the state was DONE in that cycle.
REQ-023 Capture latency from start SHALL be exactly SETTLE+DEPTH next_ready pulses; done rises on the cycle after the last storing pulse.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE, counters 0, rd_data 0, q_hit 0, period 0, busy 0, done 0.
REQ-025 Buffer contents need not be reset; q_hit SHALL still read 0 until a capture completes.
REQ-026 Reset mid-capture SHALL abort it; after release the block waits in IDLE for start.

Configuration
REQ-027 With macro LOGS_ORBIT_PERIOD_EN defined, the block SHALL add output period, clog2(DEPTH)+1 bits, reset 0.
REQ-028 With it defined, each CAPTURE write at wr_idx=k>=1 with period=0 and x==buffer[0] SHALL set period to k; period holds until the next start (which clears it) or reset; 0 means no repeat within DEPTH.
REQ-029 Without LOGS_ORBIT_PERIOD_EN, the period port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Test: DEPTH=8, SETTLE=16; start, then 24 next_ready with x=0..23 mod 16 -> done after 24th pulse; rd_addr=0..7 gives 0,1,...,7 (values 16..23 mod 16) one cycle later.
REQ-031 Test: start and next_ready coincide, then 24 further pulses -> done only after the 24th further pulse; coincident x never stored.
REQ-032 Test: after done, q_value=5 with 5 stored -> q_hit=1 next cycle; q_value=15 not stored -> q_hit=0; during busy, q_hit=0.
REQ-033 Test: rst_n low after 10 captured pulses -> busy=0, done=0, q_hit=0 immediately; further next_ready ignored until start.
REQ-034 Test (LOGS_ORBIT_PERIOD_EN): captured x sequence 3,9,3,9,... -> period=2 at done; constant x=7 -> period=1; all-distinct samples -> period=0.
REQ-035 Test: start issued while in DONE -> busy=1 next cycle; old buffer stays readable on rd_data until overwritten.

Source files
------------

// File: rtl/logs_orbit_capture.sv
// Logistic-map orbit capture: discards SETTLE iterates, stores DEPTH samples; rd_data/q_hit 1-cycle latency.
// No backpressure (next_ready is a pulse, extra pulses ignored outside SETTLE/CAPTURE); LOGS_ORBIT_PERIOD_EN adds period output.
module logs_orbit_capture #(
   parameter int FRAC   = 4,
   parameter int DEPTH  = 8,
   parameter int SETTLE = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [FRAC-1:0]            x,
   input  logic                       next_ready,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr,
   output logic [FRAC-1:0]            rd_data,
   input  logic [FRAC-1:0]            q_value,
   output logic                       q_hit,
   output logic                       busy,
   output logic                       done
`ifdef LOGS_ORBIT_PERIOD_EN
   ,output logic [$clog2(DEPTH):0]    period
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(SETTLE + 2);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   settle_q, settle_d;
   logic [AW-1:0]   wr_idx_q, wr_idx_d;
   logic            wr_en;
   logic [FRAC-1:0] mem_q [DEPTH];
   logic [FRAC-1:0] rd_data_q, rd_data_d;
   logic            q_hit_q, q_hit_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            any_match;
`ifdef LOGS_ORBIT_PERIOD_EN
   logic [AW:0]     period_q, period_d;
`endif

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      wr_idx_d = wr_idx_q;
      wr_en    = 1'b0;
`ifdef LOGS_ORBIT_PERIOD_EN
      period_d = period_q;
`endif
      // start wins over a coincident next_ready; that iterate is dropped
      if (start) begin
         state_d  = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
         settle_d = '0;
         wr_idx_d = '0;
`ifdef LOGS_ORBIT_PERIOD_EN
         period_d = '0;
`endif
      end else if (next_ready) begin
         case (state_q)
            S_SETTLE: begin
               settle_d = settle_q + 1'b1;
               if (settle_q == SW'(SETTLE - 1))
                  state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
               wr_en = 1'b1;
               if (wr_idx_q == AW'(DEPTH - 1))
                  state_d = S_DONE;
               else
                  wr_idx_d = wr_idx_q + 1'b1;
`ifdef LOGS_ORBIT_PERIOD_EN
               if (wr_idx_q != '0 && period_q == '0 && x == mem_q[0])
                  period_d = {1'b0, wr_idx_q};
`endif
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      any_match = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (mem_q[i] == q_value)
            any_match = 1'b1;
      q_hit_d   = (state_q == S_DONE) && any_match;
      rd_data_d = mem_q[rd_addr];
      busy_d    = (state_d == S_SETTLE) || (state_d == S_CAPTURE);
      done_d    = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         settle_q  <= '0;
         wr_idx_q  <= '0;
         rd_data_q <= '0;
         q_hit_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef LOGS_ORBIT_PERIOD_EN
         period_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         wr_idx_q  <= wr_idx_d;
         rd_data_q <= rd_data_d;
         q_hit_q   <= q_hit_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef LOGS_ORBIT_PERIOD_EN
         period_q  <= period_d;
`endif
      end
   end

   // Sample storage is deliberately unreset; q_hit is gated by state instead
   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[wr_idx_q] <= x;
   end

   assign rd_data = rd_data_q;
   assign q_hit   = q_hit_q;
   assign busy    = busy_q;
   assign done    = done_q;
`ifdef LOGS_ORBIT_PERIOD_EN
   assign period  = period_q;
`endif

endmodule
